// File: rtl/memory_burst_master.sv
// Burst initiator for the single-port line memory: FILL streams one line of words
// into the memory, DRAIN streams one line out of it.
module memory_burst_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WORDS = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic                  REQ_WRITE,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic                  FILL_VALID,
    input  logic [DATA_WIDTH-1:0] FILL_DATA,
    output logic                  FILL_READY,
    output logic                  DRAIN_VALID,
    output logic [DATA_WIDTH-1:0] DRAIN_DATA,
    input  logic                  DRAIN_READY,
    output logic                  MEM_WREN,
    output logic [ADDR_WIDTH-1:0] MEM_WADDR,
    output logic [DATA_WIDTH-1:0] MEM_WDATA,
    output logic [ADDR_WIDTH-1:0] MEM_RADDR,
    input  logic [DATA_WIDTH-1:0] MEM_RDATA,
    output logic                  DONE
);

    localparam int CNT_W = $clog2(LINE_WORDS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_WORDS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LINE_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_DRAIN,
        ST_FIN
    } state_t;

    state_t                  state_reg;
    logic [ADDR_WIDTH-1:0]   base_reg;
    logic [CNT_W-1:0]        wr_cnt_reg;
    logic [CNT_W-1:0]        rd_cnt_reg;
    logic                    req_ready_reg;
    logic                    fill_ready_reg;
    logic                    drain_valid_reg;
    logic [DATA_WIDTH-1:0]   drain_data_reg;
    logic                    mem_wren_reg;
    logic [ADDR_WIDTH-1:0]   mem_waddr_reg;
    logic [DATA_WIDTH-1:0]   mem_wdata_reg;
    logic [ADDR_WIDTH-1:0]   mem_raddr_reg;
    logic                    done_reg;

    logic [ADDR_WIDTH-1:0]   wr_addr_next;
    logic [ADDR_WIDTH-1:0]   rd_addr_next;
    logic                    drain_load;

    // Addresses wrap modulo 2^ADDR_WIDTH through plain truncating addition.
    assign wr_addr_next = base_reg + ADDR_WIDTH'(wr_cnt_reg);
    assign rd_addr_next = base_reg + ADDR_WIDTH'(rd_cnt_reg) + ADDR_WIDTH'(1);
    assign drain_load   = (!drain_valid_reg || DRAIN_READY) && (rd_cnt_reg < FULL_CNT);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg       <= ST_IDLE;
            base_reg        <= '0;
            wr_cnt_reg      <= '0;
            rd_cnt_reg      <= '0;
            req_ready_reg   <= 1'b1;
            fill_ready_reg  <= 1'b0;
            drain_valid_reg <= 1'b0;
            drain_data_reg  <= '0;
            mem_wren_reg    <= 1'b0;
            mem_waddr_reg   <= '0;
            mem_wdata_reg   <= '0;
            mem_raddr_reg   <= '0;
            done_reg        <= 1'b0;
        end else begin
            mem_wren_reg <= 1'b0;
            done_reg     <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (REQ_VALID) begin
                        base_reg      <= REQ_ADDR;
                        mem_raddr_reg <= REQ_ADDR;
                        wr_cnt_reg    <= '0;
                        rd_cnt_reg    <= '0;
                        req_ready_reg <= 1'b0;
                        if (REQ_WRITE) begin
                            state_reg      <= ST_FILL;
                            fill_ready_reg <= 1'b1;
                        end else begin
                            state_reg <= ST_DRAIN;
                        end
                    end
                end
                ST_FILL: begin
                    // FILL_READY stays high for the whole FILL state: the state is left on the last beat.
                    if (FILL_VALID) begin
                        mem_wren_reg  <= 1'b1;
                        mem_waddr_reg <= wr_addr_next;
                        mem_wdata_reg <= FILL_DATA;
                        wr_cnt_reg    <= wr_cnt_reg + CNT_W'(1);
                        if (wr_cnt_reg == LAST_IDX) begin
                            fill_ready_reg <= 1'b0;
                            state_reg      <= ST_FIN;
                            done_reg       <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_load) begin
                        drain_data_reg  <= MEM_RDATA;
                        drain_valid_reg <= 1'b1;
                        rd_cnt_reg      <= rd_cnt_reg + CNT_W'(1);
                        mem_raddr_reg   <= rd_addr_next;
                    end else if (drain_valid_reg && DRAIN_READY) begin
                        // Last word consumed with nothing left to read.
                        drain_valid_reg <= 1'b0;
                        state_reg       <= ST_FIN;
                        done_reg        <= 1'b1;
                    end
                end
                ST_FIN: begin
                    state_reg     <= ST_IDLE;
                    req_ready_reg <= 1'b1;
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    req_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign REQ_READY   = req_ready_reg;
    assign FILL_READY  = fill_ready_reg;
    assign DRAIN_VALID = drain_valid_reg;
    assign DRAIN_DATA  = drain_data_reg;
    assign MEM_WREN    = mem_wren_reg;
    assign MEM_WADDR   = mem_waddr_reg;
    assign MEM_WDATA   = mem_wdata_reg;
    assign MEM_RADDR   = mem_raddr_reg;
    assign DONE        = done_reg;

endmodule

// File: tb/tb_memory_burst_master.sv
// Scoreboard bench for memory_burst_master: a behavioural memory plus a reference
// copy of what the line contents should be after each fill.
module tb_memory_burst_master;

    localparam int DW = 32;
    localparam int AW = 9;
    localparam int LW = 8;

    logic          CLK;
    logic          RST;
    logic          REQ_VALID;
    logic          REQ_READY;
    logic          REQ_WRITE;
    logic [AW-1:0] REQ_ADDR;
    logic          FILL_VALID;
    logic [DW-1:0] FILL_DATA;
    logic          FILL_READY;
    logic          DRAIN_VALID;
    logic [DW-1:0] DRAIN_DATA;
    logic          DRAIN_READY;
    logic          MEM_WREN;
    logic [AW-1:0] MEM_WADDR;
    logic [DW-1:0] MEM_WDATA;
    logic [AW-1:0] MEM_RADDR;
    logic [DW-1:0] MEM_RDATA;
    logic          DONE;

    memory_burst_master #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .LINE_WORDS(LW)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .REQ_VALID  (REQ_VALID),
        .REQ_READY  (REQ_READY),
        .REQ_WRITE  (REQ_WRITE),
        .REQ_ADDR   (REQ_ADDR),
        .FILL_VALID (FILL_VALID),
        .FILL_DATA  (FILL_DATA),
        .FILL_READY (FILL_READY),
        .DRAIN_VALID(DRAIN_VALID),
        .DRAIN_DATA (DRAIN_DATA),
        .DRAIN_READY(DRAIN_READY),
        .MEM_WREN   (MEM_WREN),
        .MEM_WADDR  (MEM_WADDR),
        .MEM_WDATA  (MEM_WDATA),
        .MEM_RADDR  (MEM_RADDR),
        .MEM_RDATA  (MEM_RDATA),
        .DONE       (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural memory: registered write, combinational read.
    logic [DW-1:0] mem [512];
    logic [DW-1:0] ref_mem [512];
    always @(posedge CLK) begin
        if (MEM_WREN) mem[MEM_WADDR] <= MEM_WDATA;
    end
    assign MEM_RDATA = mem[MEM_RADDR];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    logic [AW+DW-1:0] wr_q [$];
    logic [DW-1:0]    dr_q [$];
    logic             stall_prev;
    logic [DW-1:0]    stall_data;
    logic [DW-1:0]    fill_words [LW];

    // Output monitor: compares every memory write and every drain beat against the queues.
    always @(negedge CLK) begin
        if (RST) begin
            wr_q.delete();
            dr_q.delete();
            stall_prev <= 1'b0;
        end else begin
            if (MEM_WREN) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    check("wr_addr", MEM_WADDR, wr_q[0][AW+DW-1:DW]);
                    check("wr_data", MEM_WDATA, wr_q[0][DW-1:0]);
                    void'(wr_q.pop_front());
                end
            end
            if (stall_prev) begin
                check("stall_valid", DRAIN_VALID, 1);
                check("stall_data", DRAIN_DATA, stall_data);
            end
            if (DRAIN_VALID && DRAIN_READY) begin
                if (dr_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    check("drain_data", DRAIN_DATA, dr_q[0]);
                    void'(dr_q.pop_front());
                end
            end
            stall_prev <= DRAIN_VALID && !DRAIN_READY;
            stall_data <= DRAIN_DATA;
        end
    end

    task automatic request(input logic wr, input logic [AW-1:0] addr);
        int t = 0;
        while (!REQ_READY && t < 50) begin
            @(posedge CLK); #1;
            t++;
        end
        check("req_ready_wait", REQ_READY, 1);
        $display("request %s base=0x%03h", wr ? "fill " : "drain", addr);
        REQ_VALID = 1'b1;
        REQ_WRITE = wr;
        REQ_ADDR  = addr;
        @(posedge CLK); #1;
        REQ_VALID = 1'b0;
        check("req_ready_busy", REQ_READY, 0);
    endtask

    // Drives n fill words from fill_words; gap inserts an idle cycle between words.
    task automatic fill_burst(input logic [AW-1:0] base, input int n, input logic gap);
        int k = 0;
        int c = 0;
        logic hs;
        logic [AW-1:0] a;
        request(1'b1, base);
        while (k < n && c < 100) begin
            FILL_VALID = gap ? (c % 2 == 0) : 1'b1;
            FILL_DATA  = fill_words[k];
            hs = FILL_VALID && FILL_READY;
            if (hs) begin
                a = base + AW'(k);
                wr_q.push_back({a, fill_words[k]});
                ref_mem[a] = fill_words[k];
            end
            @(posedge CLK); #1;
            check("fill_wren", MEM_WREN, hs);
            if (hs) k++;
            c++;
        end
        FILL_VALID = 1'b0;
        check("fill_beats", k, n);
        if (n == LW) begin
            check("fill_done_with_last", DONE, 1);
            @(posedge CLK); #1;
            check("fill_done_pulse", DONE, 0);
            check("fill_wren_after", MEM_WREN, 0);
            check("fill_req_ready", REQ_READY, 1);
        end
    endtask

    // pat[c%4] gives DRAIN_READY on cycle c after acceptance.
    task automatic drain_burst(input logic [AW-1:0] base, input logic [3:0] pat);
        int beats = 0;
        int c = 0;
        logic hs;
        for (int i = 0; i < LW; i++) dr_q.push_back(ref_mem[base + AW'(i)]);
        request(1'b0, base);
        check("drain_valid_lat1", DRAIN_VALID, 0);
        while (beats < LW && c < 100) begin
            DRAIN_READY = pat[c % 4];
            hs = DRAIN_VALID && DRAIN_READY;
            @(posedge CLK); #1;
            if (c == 0) check("drain_valid_lat2", DRAIN_VALID, 1);
            if (hs) beats++;
            c++;
        end
        check("drain_beats", beats, LW);
        if (pat == 4'hF) check("drain_cycles", c, LW + 1);
        check("drain_done", DONE, 1);
        check("drain_valid_end", DRAIN_VALID, 0);
        DRAIN_READY = 1'b1;
        @(posedge CLK); #1;
        check("drain_done_pulse", DONE, 0);
        check("drain_no_extra", DRAIN_VALID, 0);
        check("drain_req_ready", REQ_READY, 1);
        DRAIN_READY = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        stall_prev  = 1'b0;
        stall_data  = '0;
        RST         = 1'b1;
        REQ_VALID   = 1'b0;
        REQ_WRITE   = 1'b0;
        REQ_ADDR    = '0;
        FILL_VALID  = 1'b0;
        FILL_DATA   = '0;
        DRAIN_READY = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_req_ready", REQ_READY, 1);
        check("rst_fill_ready", FILL_READY, 0);
        check("rst_drain_valid", DRAIN_VALID, 0);
        check("rst_wren", MEM_WREN, 0);
        check("rst_done", DONE, 0);
        RST = 1'b0;
        @(posedge CLK); #1;

        // Back-to-back fill, then a fill with a gap every other cycle.
        for (int i = 0; i < LW; i++) fill_words[i] = 32'hA0 + i;
        fill_burst(9'h010, LW, 1'b0);
        for (int i = 0; i < LW; i++) fill_words[i] = 32'hB0 + i;
        fill_burst(9'h040, LW, 1'b1);

        // Drains at full rate and with a 1,0,0,1 ready pattern.
        drain_burst(9'h010, 4'hF);
        drain_burst(9'h010, 4'b1001);
        drain_burst(9'h040, 4'b0110);

        // Address wrap across the top of a 9-bit space.
        for (int i = 0; i < LW; i++) fill_words[i] = 32'hC0 + i;
        fill_burst(9'h1FC, LW, 1'b0);
        drain_burst(9'h1FC, 4'hF);

        // Reset while the fourth write is on the bus; that word carries the old contents.
        fill_words[0] = 32'hD0;
        fill_words[1] = 32'hD1;
        fill_words[2] = 32'hD2;
        fill_words[3] = ref_mem[9'h013];
        fill_burst(9'h010, 4, 1'b0);
        RST = 1'b1;
        #1;
        check("midrst_wren", MEM_WREN, 0);
        check("midrst_done", DONE, 0);
        check("midrst_fill_ready", FILL_READY, 0);
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        check("midrst_req_ready", REQ_READY, 1);
        drain_burst(9'h010, 4'hF);

        repeat (3) @(posedge CLK);
        #1;
        check("wr_queue_empty", wr_q.size(), 0);
        check("drain_queue_empty", dr_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
